// File: rtl/mac_pkg.sv
// Shared MAC operand-path definitions: operand width, channel indices and a
// ceiling-log2 helper used to size FIFO pointers.
package mac_pkg;

  localparam int MAC_OPERAND_WIDTH = 8;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_channel_fifo.sv
// Per-channel operand FIFO: DEPTH entries (power of two), head entry shown
// combinationally; when empty the head shows the most recently popped byte.
module demux_channel_fifo
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_OPERAND_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // An empty FIFO keeps presenting the last byte it handed out.
  assign head_data = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
      if (do_pop)  last_q <= mem_q[rd_ptr_q];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_operand_demux.sv
// 1-to-2 operand demux feeding two MAC operand FIFOs. With DEMUX_ALTERNATE_EN
// defined, an internal toggle replaces in_sel and alternates channels 0,1,0,1.
module mac_operand_demux
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_OPERAND_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  logic dest;
  logic accept;
  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;

`ifdef DEMUX_ALTERNATE_EN
  logic toggle_q, toggle_d;
  logic in_sel_unused;

  assign in_sel_unused = in_sel;
  assign dest          = toggle_q;

  // The toggle only moves when a byte is actually taken, so a stall on the
  // targeted channel keeps pointing at that channel.
  always_comb begin
    toggle_d = toggle_q;
    if (accept) toggle_d = ~toggle_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle_q <= 1'b0;
    else     toggle_q <= toggle_d;
  end
`else
  assign dest = in_sel;
`endif

  // Full check ignores a same-cycle pop to keep in_ready off the consumer path.
  assign in_ready = !rst && !((dest == CH_B) ? full1 : full0);
  assign accept   = in_valid && in_ready;

  assign push0 = accept && (dest == CH_A);
  assign push1 = accept && (dest == CH_B);
  assign pop0  = out0_ready && !empty0;
  assign pop1  = out1_ready && !empty1;

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  demux_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head_data (out0_data)
  );

  demux_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head_data (out1_data)
  );

endmodule

// File: tb/tb_mac_operand_demux.sv
// Directed bench for mac_operand_demux: per-cycle vector table plus reset and
// streaming sequences; covers both builds of DEMUX_ALTERNATE_EN.
module tb_mac_operand_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_operand_demux #(.WIDTH(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       ir;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic r0, logic r1,
                              logic ir, logic v0, logic [7:0] d0, logic v1, logic [7:0] d1);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1;
    t.ir = ir; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

`ifdef DEMUX_ALTERNATE_EN
    // in_sel held at 1; toggle decides the channel
    vecs.push_back(mk(1,1,8'h01, 1,1, 1, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(1,1,8'h02, 1,1, 1, 1,8'h01, 0,8'h00));
    vecs.push_back(mk(1,1,8'h03, 1,1, 1, 0,8'h00, 1,8'h02));
    vecs.push_back(mk(1,1,8'h04, 1,1, 1, 1,8'h03, 0,8'h00));
    vecs.push_back(mk(0,1,8'h00, 1,1, 1, 0,8'h00, 1,8'h04));
    vecs.push_back(mk(0,1,8'h00, 1,1, 1, 0,8'h00, 0,8'h00));
    // channel 1 blocked: fills, then stalls with the toggle pointing at it
    vecs.push_back(mk(1,1,8'h05, 1,0, 1, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(1,1,8'h06, 1,0, 1, 1,8'h05, 0,8'h00));
    vecs.push_back(mk(1,1,8'h07, 1,0, 1, 0,8'h00, 1,8'h06));
    vecs.push_back(mk(1,1,8'h08, 1,0, 1, 1,8'h07, 1,8'h06));
    vecs.push_back(mk(1,1,8'h09, 1,0, 1, 0,8'h00, 1,8'h06));
    vecs.push_back(mk(1,1,8'h0A, 1,0, 0, 1,8'h09, 1,8'h06));
    vecs.push_back(mk(1,1,8'h0A, 1,0, 0, 0,8'h00, 1,8'h06));
    vecs.push_back(mk(1,1,8'h0A, 1,1, 0, 0,8'h00, 1,8'h06));
    vecs.push_back(mk(1,1,8'h0A, 1,0, 1, 0,8'h00, 1,8'h08));
    vecs.push_back(mk(0,1,8'h00, 1,1, 1, 0,8'h00, 1,8'h08));
    vecs.push_back(mk(0,1,8'h00, 1,1, 1, 0,8'h00, 1,8'h0A));
    vecs.push_back(mk(0,1,8'h00, 1,1, 1, 0,8'h00, 0,8'h00));
`else
    // steering
    vecs.push_back(mk(1,0,8'h11, 1,1, 1, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(1,1,8'h22, 1,1, 1, 1,8'h11, 0,8'h00));
    vecs.push_back(mk(1,0,8'h33, 1,1, 1, 0,8'h00, 1,8'h22));
    vecs.push_back(mk(0,0,8'h00, 1,1, 1, 1,8'h33, 0,8'h00));
    vecs.push_back(mk(0,0,8'h00, 1,1, 1, 0,8'h00, 0,8'h00));
    // full / backpressure on channel 0
    vecs.push_back(mk(1,0,8'hA0, 0,1, 1, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,8'hA1, 0,1, 1, 1,8'hA0, 0,8'h00));
    vecs.push_back(mk(1,0,8'hA2, 0,1, 0, 1,8'hA0, 0,8'h00));
    vecs.push_back(mk(1,0,8'hA2, 1,1, 0, 1,8'hA0, 0,8'h00));
    vecs.push_back(mk(1,0,8'hA2, 0,1, 1, 1,8'hA1, 0,8'h00));
    vecs.push_back(mk(0,0,8'h00, 1,1, 0, 1,8'hA1, 0,8'h00));
    vecs.push_back(mk(0,0,8'h00, 1,1, 1, 1,8'hA2, 0,8'h00));
    vecs.push_back(mk(0,0,8'h00, 0,1, 1, 0,8'h00, 0,8'h00));
    // head-of-line blocking: 0x55 stalls, channel 1 stays empty
    vecs.push_back(mk(1,0,8'h50, 0,1, 1, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,8'h51, 0,1, 1, 1,8'h50, 0,8'h00));
    vecs.push_back(mk(1,0,8'h55, 0,1, 0, 1,8'h50, 0,8'h00));
    vecs.push_back(mk(1,0,8'h55, 0,1, 0, 1,8'h50, 0,8'h00));
    vecs.push_back(mk(1,0,8'h55, 1,1, 0, 1,8'h50, 0,8'h00));
    vecs.push_back(mk(1,0,8'h55, 0,1, 1, 1,8'h51, 0,8'h00));
    vecs.push_back(mk(1,1,8'h66, 0,1, 1, 1,8'h51, 0,8'h00));
    vecs.push_back(mk(0,0,8'h00, 1,1, 0, 1,8'h51, 1,8'h66));
    vecs.push_back(mk(0,0,8'h00, 1,1, 1, 1,8'h55, 0,8'h00));
    vecs.push_back(mk(0,0,8'h00, 1,1, 1, 0,8'h00, 0,8'h00));
`endif

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ir);
      chk($sformatf("v%0d_out0_valid", i), out0_valid, vecs[i].v0);
      chk($sformatf("v%0d_out1_valid", i), out1_valid, vecs[i].v1);
      if (vecs[i].v0) chk($sformatf("v%0d_out0_data", i), out0_data, vecs[i].d0);
      if (vecs[i].v1) chk($sformatf("v%0d_out1_data", i), out1_data, vecs[i].d1);
    end

    // empty channels keep showing the last popped byte
`ifdef DEMUX_ALTERNATE_EN
    chk("hold_out0_data", out0_data, 8'h09);
    chk("hold_out1_data", out1_data, 8'h0A);
`else
    chk("hold_out0_data", out0_data, 8'h55);
    chk("hold_out1_data", out1_data, 8'h66);

    // back-to-back push/pop on channel 1 with pointer wrap
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
      #1;
      chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
      chk($sformatf("stream%0d_out1_valid", i), out1_valid, (i > 0) ? 1 : 0);
      if (i > 0) chk($sformatf("stream%0d_out1_data", i), out1_data, i - 1);
      chk($sformatf("stream%0d_out0_valid", i), out0_valid, 0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    chk("stream_last_valid", out1_valid, 1);
    chk("stream_last_data", out1_data, 8'h09);
    @(negedge clk);
    #1;
    chk("stream_drained", out1_valid, 0);
`endif

    // reset mid-traffic with two bytes queued
    @(negedge clk);
    drive(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("pre_rst_out0_valid", out0_valid, 1);
    rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mid_rst%0d_in_ready", c), in_ready, 0);
      chk($sformatf("mid_rst%0d_out0_valid", c), out0_valid, 0);
      chk($sformatf("mid_rst%0d_out1_valid", c), out1_valid, 0);
      chk($sformatf("mid_rst%0d_out0_data", c), out0_data, 0);
      chk($sformatf("mid_rst%0d_out1_data", c), out1_data, 0);
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out0_valid", out0_valid, 0);
    chk("post_rst_out1_valid", out1_valid, 0);

    // first byte after reset lands in channel 0 in both builds
    @(negedge clk);
`ifdef DEMUX_ALTERNATE_EN
    drive(1'b1, 1'b1, 8'hD7, 1'b0, 1'b0);
`else
    drive(1'b1, 1'b0, 8'hD7, 1'b0, 1'b0);
`endif
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("post_rst_push_valid0", out0_valid, 1);
    chk("post_rst_push_data0", out0_data, 8'hD7);
    chk("post_rst_push_valid1", out1_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
